// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted-priority arbiter between two virtual-channel FIFOs.
// VC0 is the high-priority channel. VC1 is guaranteed one grant after WEIGHT
// consecutive VC0 grants while it waits. A head word is popped only when the
// destination FIFO selected by its bit 4 is not almost-full.
module vc_arbiter #(
    parameter int BW     = 6,
    parameter int WEIGHT = 3,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic [BW-1:0] VC0_data_out,
    input  logic          VC0_empty,
    output logic          VC0_rd,
    input  logic [BW-1:0] VC1_data_out,
    input  logic          VC1_empty,
    output logic          VC1_rd,
    input  logic          D0_almost_full,
    input  logic          D1_almost_full,
    output logic [BW-1:0] arb_data_out,
    output logic          arb_valid_out,
    output logic [1:0]    arb_state,
    output logic [CW-1:0] starve_cnt
);

    localparam logic [CW-1:0] WEIGHT_C = CW'(WEIGHT);
    localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } arb_state_e;

    logic          elig0_s;
    logic          elig1_s;
    logic          gnt0_s;
    logic          gnt1_s;
    logic [BW-1:0] data_d,   data_q;
    logic          valid_d,  valid_q;
    logic [CW-1:0] starve_d, starve_q;
    arb_state_e    state_d,  state_q;

    // Eligibility: head present and its own destination has room.
    always_comb begin
        elig0_s = 1'b0;
        elig1_s = 1'b0;
        if (VC0_data_out[4]) begin
            elig0_s = !VC0_empty && !D1_almost_full;
        end else begin
            elig0_s = !VC0_empty && !D0_almost_full;
        end
        if (VC1_data_out[4]) begin
            elig1_s = !VC1_empty && !D1_almost_full;
        end else begin
            elig1_s = !VC1_empty && !D0_almost_full;
        end
    end

    // Grant selection; no pops are issued while reset is held.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset_L) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (elig0_s && elig1_s) begin
            if (starve_q == WEIGHT_C) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (elig0_s) begin
            gnt0_s = 1'b1;
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign VC0_rd = gnt0_s;
    assign VC1_rd = gnt1_s;

    // Next-state for output word, starvation counter and status.
    always_comb begin
        data_d   = data_q;
        valid_d  = 1'b0;
        starve_d = starve_q;
        state_d  = ST_IDLE;

        if (gnt0_s) begin
            data_d  = VC0_data_out;
            valid_d = 1'b1;
        end else if (gnt1_s) begin
            data_d  = VC1_data_out;
            valid_d = 1'b1;
        end else begin
            data_d  = data_q;
            valid_d = 1'b0;
        end

        // An empty VC1 has nothing to be starved of, so the count clears.
        if (VC1_empty || gnt1_s) begin
            starve_d = {CW{1'b0}};
        end else if (gnt0_s) begin
            if (starve_q >= WEIGHT_C) begin
                starve_d = WEIGHT_C;
            end else begin
                starve_d = starve_q + ONE_C;
            end
        end else begin
            starve_d = starve_q;
        end

        if (gnt0_s || gnt1_s) begin
            state_d = ST_ACTIVE;
        end else if (!VC0_empty || !VC1_empty) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            data_q   <= {BW{1'b0}};
            valid_q  <= 1'b0;
            starve_q <= {CW{1'b0}};
            state_q  <= ST_IDLE;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            starve_q <= starve_d;
            state_q  <= state_d;
        end
    end

    assign arb_data_out  = data_q;
    assign arb_valid_out = valid_q;
    assign arb_state     = state_q;
    assign starve_cnt    = starve_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed testbench for vc_arbiter: queue-based FIFO models feed a
// WEIGHT=3 instance and a WEIGHT=1 instance sharing clock and reset.
module tb_vc_arbiter;

    logic       clk;
    logic       reset_L;

    logic [5:0] vc0_data, vc1_data;
    logic       vc0_empty, vc1_empty, vc0_rd, vc1_rd;
    logic       d0_af, d1_af;
    logic [5:0] arb_data;
    logic       arb_valid;
    logic [1:0] arb_state;
    logic [3:0] starve;

    logic [5:0] w_vc0_data, w_vc1_data;
    logic       w_vc0_empty, w_vc1_empty, w_vc0_rd, w_vc1_rd;
    logic [5:0] w_arb_data;
    logic       w_arb_valid;
    logic [1:0] w_arb_state;
    logic [3:0] w_starve;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [5:0] wq0[$];
    logic [5:0] wq1[$];

    int checks = 0;
    int errors = 0;

    vc_arbiter #(.BW(6), .WEIGHT(3), .CW(4)) dut (
        .clk(clk), .reset_L(reset_L),
        .VC0_data_out(vc0_data), .VC0_empty(vc0_empty), .VC0_rd(vc0_rd),
        .VC1_data_out(vc1_data), .VC1_empty(vc1_empty), .VC1_rd(vc1_rd),
        .D0_almost_full(d0_af), .D1_almost_full(d1_af),
        .arb_data_out(arb_data), .arb_valid_out(arb_valid),
        .arb_state(arb_state), .starve_cnt(starve)
    );

    vc_arbiter #(.BW(6), .WEIGHT(1), .CW(4)) dut_w1 (
        .clk(clk), .reset_L(reset_L),
        .VC0_data_out(w_vc0_data), .VC0_empty(w_vc0_empty), .VC0_rd(w_vc0_rd),
        .VC1_data_out(w_vc1_data), .VC1_empty(w_vc1_empty), .VC1_rd(w_vc1_rd),
        .D0_almost_full(1'b0), .D1_almost_full(1'b0),
        .arb_data_out(w_arb_data), .arb_valid_out(w_arb_valid),
        .arb_state(w_arb_state), .starve_cnt(w_starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present queue heads to both DUTs, then let combinational logic settle.
    task automatic upd();
        vc0_empty   = (q0.size() == 0);
        vc0_data    = vc0_empty ? 6'h00 : q0[0];
        vc1_empty   = (q1.size() == 0);
        vc1_data    = vc1_empty ? 6'h00 : q1[0];
        w_vc0_empty = (wq0.size() == 0);
        w_vc0_data  = w_vc0_empty ? 6'h00 : wq0[0];
        w_vc1_empty = (wq1.size() == 0);
        w_vc1_data  = w_vc1_empty ? 6'h00 : wq1[0];
        #1;
    endtask

    // One clock: capture strobes, pass the edge, pop what was strobed.
    task automatic step();
        logic r0, r1, wr0, wr1;
        r0 = vc0_rd; r1 = vc1_rd; wr0 = w_vc0_rd; wr1 = w_vc1_rd;
        @(posedge clk);
        #1;
        if (r0)  void'(q0.pop_front());
        if (r1)  void'(q1.pop_front());
        if (wr0) void'(wq0.pop_front());
        if (wr1) void'(wq1.pop_front());
        upd();
    endtask

    logic [5:0] exp_seq [12];
    logic [3:0] exp_cnt [4];

    initial begin
        exp_seq = '{6'h01, 6'h02, 6'h03, 6'h21, 6'h04, 6'h05,
                    6'h06, 6'h22, 6'h07, 6'h08, 6'h23, 6'h24};
        exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd3};
        reset_L = 1'b0;
        d0_af = 1'b0;
        d1_af = 1'b0;
        q0 = {6'h01, 6'h02};
        q1 = {6'h21};
        upd();

        // Reset held with both VCs non-empty.
        for (int i = 0; i < 3; i++) begin
            check("rst_rd0", {31'd0, vc0_rd}, 32'd0);
            check("rst_rd1", {31'd0, vc1_rd}, 32'd0);
            step();
            check("rst_valid", {31'd0, arb_valid}, 32'd0);
            check("rst_state", {30'd0, arb_state}, 32'd0);
            check("rst_starve", {28'd0, starve}, 32'd0);
        end
        check("rst_nopop", q0.size(), 32'd2);

        // Weighted priority, WEIGHT=3.
        q0 = {6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08};
        q1 = {6'h21, 6'h22, 6'h23, 6'h24};
        reset_L = 1'b1;
        upd();
        for (int i = 0; i < 12; i++) begin
            check("wp_excl", {31'd0, vc0_rd & vc1_rd}, 32'd0);
            step();
            check("wp_data", {26'd0, arb_data}, {26'd0, exp_seq[i]});
            check("wp_valid", {31'd0, arb_valid}, 32'd1);
            check("wp_state", {30'd0, arb_state}, 32'd1);
        end
        step();
        check("wp_end_valid", {31'd0, arb_valid}, 32'd0);
        check("wp_end_state", {30'd0, arb_state}, 32'd0);

        // Per-destination backpressure: VC0 blocked on D1, VC1 proceeds.
        d1_af = 1'b1;
        q0 = {6'h11};
        q1 = {6'h02};
        upd();
        check("bp_rd0", {31'd0, vc0_rd}, 32'd0);
        check("bp_rd1", {31'd0, vc1_rd}, 32'd1);
        step();
        check("bp_data1", {26'd0, arb_data}, 32'h02);
        check("bp_valid1", {31'd0, arb_valid}, 32'd1);
        check("bp_rd0_blk", {31'd0, vc0_rd}, 32'd0);
        step();
        check("bp_stall_valid", {31'd0, arb_valid}, 32'd0);
        check("bp_stall_state", {30'd0, arb_state}, 32'd2);
        d1_af = 1'b0;
        upd();
        check("bp_rel_rd0", {31'd0, vc0_rd}, 32'd1);
        step();
        check("bp_data2", {26'd0, arb_data}, 32'h11);
        check("bp_valid2", {31'd0, arb_valid}, 32'd1);

        // Full stall then drain to idle.
        d0_af = 1'b1;
        q0 = {6'h03};
        q1 = {6'h04};
        upd();
        check("fs_rd0", {31'd0, vc0_rd}, 32'd0);
        check("fs_rd1", {31'd0, vc1_rd}, 32'd0);
        step();
        check("fs_state", {30'd0, arb_state}, 32'd2);
        check("fs_valid", {31'd0, arb_valid}, 32'd0);
        check("fs_hold", {26'd0, arb_data}, 32'h11);
        q0.delete();
        q1.delete();
        d0_af = 1'b0;
        upd();
        step();
        check("fs_idle", {30'd0, arb_state}, 32'd0);

        // Ineligible VC1 still accumulates; wins as soon as it is eligible.
        d1_af = 1'b1;
        q0 = {6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
        q1 = {6'h31};
        upd();
        for (int i = 0; i < 4; i++) begin
            step();
            check("sv_data", {26'd0, arb_data}, 32'(i + 1));
            check("sv_cnt", {28'd0, starve}, {28'd0, exp_cnt[i]});
        end
        d1_af = 1'b0;
        upd();
        check("sv_rd1", {31'd0, vc1_rd}, 32'd1);
        check("sv_rd0", {31'd0, vc0_rd}, 32'd0);
        step();
        check("sv_win", {26'd0, arb_data}, 32'h31);
        check("sv_cnt0", {28'd0, starve}, 32'd0);
        step();
        check("sv_tail", {26'd0, arb_data}, 32'h05);

        // Reset mid-stream drops the in-flight word.
        q0 = {6'h05, 6'h06};
        upd();
        step();
        check("rm_data", {26'd0, arb_data}, 32'h05);
        check("rm_valid", {31'd0, arb_valid}, 32'd1);
        reset_L = 1'b0;
        upd();
        check("rm_rd0", {31'd0, vc0_rd}, 32'd0);
        step();
        check("rm_valid0", {31'd0, arb_valid}, 32'd0);
        check("rm_data0", {26'd0, arb_data}, 32'd0);
        check("rm_starve", {28'd0, starve}, 32'd0);
        reset_L = 1'b1;
        upd();
        step();
        check("rm_resume", {26'd0, arb_data}, 32'h06);
        check("rm_resume_v", {31'd0, arb_valid}, 32'd1);

        // WEIGHT=1 alternation with both VCs continuously full.
        wq0 = {6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0a};
        wq1 = {6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h28, 6'h29, 6'h2a};
        upd();
        for (int i = 0; i < 8; i++) begin
            check("alt_rd0", {31'd0, w_vc0_rd}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("alt_rd1", {31'd0, w_vc1_rd}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check("alt_valid", {31'd0, w_arb_valid}, 32'd1);
        end
        check("alt_data", {26'd0, w_arb_data}, 32'h24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
